// File: rtl/cam_line_realign.sv
// cam_line_realign: ping-pong camera line buffer replayed as a fixed H_ACT window aligned to sync_gen hsync/vsync
//   clk, rstn                   : shared pixel clock, asynchronous active-low reset
//   cam_href, cam_vsync         : camera line valid (one pixel per clk) and frame sync
//   cam_data [DW]               : camera pixel
//   hsync, vsync                : regenerated syncs from sync_gen
//   hsync_o, vsync_o            : syncs delayed 2 clk to line up with de/pix_data
//   de, pix_data [DW]           : replayed window; pixel is 0 outside de and past the stored line length
//   ovf, udf, trunc             : sticky camera-line-dropped / output-line-skipped / camera-line-truncated
module cam_line_realign #(
    parameter int H_ACT = 1280,
    parameter int H_BP  = 40,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cam_href,
    input  logic          cam_vsync,
    input  logic [DW-1:0] cam_data,
    input  logic          hsync,
    input  logic          vsync,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de,
    output logic [DW-1:0] pix_data,
    output logic          ovf,
    output logic          udf,
    output logic          trunc
);
    localparam int AW = $clog2(H_ACT + 1);
    localparam int IW = $clog2(H_ACT);
    localparam int BW = $clog2(H_BP + 1);
    localparam logic [AW-1:0] N_ACT = AW'(H_ACT);
    localparam logic [AW-1:0] LAST  = AW'(H_ACT - 1);

    typedef enum logic [1:0] {IDLE, BP, ACT} state_t;

    state_t        state;
    logic [DW-1:0] mem [2][H_ACT];
    logic [DW-1:0] rdata;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [AW-1:0] len [2];
    logic [1:0]    full;
    logic [BW-1:0] bp_cnt;
    logic          wr_bank, rd_bank, cur, drop, no_clr;
    logic          href_q, hs_q, cvs_q, hs_d, vs_d, act_q, pad_q;
    logic          href_rise, href_fall, hs_fall, cvs_rise, wr_go, wr_ok;

    assign href_rise = cam_href & ~href_q;
    assign href_fall = ~cam_href & href_q;
    assign hs_fall   = ~hsync & hs_q;
    assign cvs_rise  = cam_vsync & ~cvs_q;
    // Keep/drop is decided on a line's first pixel and held for the rest of it
    assign wr_go     = cam_href & ~(href_rise ? full[wr_bank] : drop);
    assign wr_ok     = wr_go & (wr_addr < N_ACT);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_bank][wr_addr[IW-1:0]] <= cam_data;
        rdata <= mem[cur][rd_addr[IW-1:0]];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            wr_addr  <= '0;
            rd_addr  <= '0;
            len[0]   <= '0;
            len[1]   <= '0;
            full     <= '0;
            bp_cnt   <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            cur      <= 1'b0;
            drop     <= 1'b0;
            no_clr   <= 1'b0;
            href_q   <= 1'b0;
            hs_q     <= 1'b0;
            cvs_q    <= 1'b0;
            hs_d     <= 1'b0;
            vs_d     <= 1'b0;
            act_q    <= 1'b0;
            pad_q    <= 1'b0;
            hsync_o  <= 1'b0;
            vsync_o  <= 1'b0;
            de       <= 1'b0;
            pix_data <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            trunc    <= 1'b0;
        end else begin
            href_q  <= cam_href;
            hs_q    <= hsync;
            cvs_q   <= cam_vsync;
            hs_d    <= hsync;
            hsync_o <= hs_d;
            vs_d    <= vsync;
            vsync_o <= vs_d;
            if (href_rise) begin
                drop <= full[wr_bank];
                if (full[wr_bank])
                    ovf <= 1'b1;
            end
            if (wr_go) begin
                if (wr_addr < N_ACT)
                    wr_addr <= wr_addr + 1'b1;
                else
                    trunc <= 1'b1;
            end
            if (href_fall) begin
                wr_addr <= '0;
                if (!drop) begin
                    len[wr_bank]  <= wr_addr;
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            case (state)
                IDLE: if (hs_fall) begin
                    if (full[rd_bank]) begin
                        cur    <= rd_bank;
                        bp_cnt <= BW'(H_BP - 1);
                        no_clr <= 1'b0;
                        state  <= BP;
                    end else
                        udf <= 1'b1;
                end
                BP: begin
                    bp_cnt <= bp_cnt - 1'b1;
                    if (bp_cnt == '0) begin
                        rd_addr <= '0;
                        state   <= ACT;
                    end
                end
                ACT: begin
                    rd_addr <= rd_addr + 1'b1;
                    if (rd_addr == LAST) begin
                        // A flush during this line already reset the bank bookkeeping
                        if (!no_clr) begin
                            full[cur] <= 1'b0;
                            rd_bank   <= ~rd_bank;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Flush last so it overrides a coincident write completion or read clear
            if (cvs_rise) begin
                full    <= '0;
                wr_bank <= 1'b0;
                wr_addr <= '0;
                rd_bank <= 1'b0;
                drop    <= 1'b0;
                no_clr  <= 1'b1;
            end
            act_q    <= (state == ACT);
            pad_q    <= (rd_addr >= len[cur]);
            de       <= act_q;
            pix_data <= (act_q && !pad_q) ? rdata : '0;
        end
    end
endmodule

// File: tb/tb_cam_line_realign.sv
// tb_cam_line_realign: directed checks of buffering, replay timing, padding, flags, flush and async reset
module tb_cam_line_realign;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cam_href = 1'b0;
    logic        cam_vsync = 1'b0;
    logic [15:0] cam_data = '0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b0;
    logic        hsync_o, vsync_o, de, ovf, udf, trunc;
    logic [15:0] pix_data;
    int          total = 0;
    int          bad = 0;

    cam_line_realign #(.H_ACT(8), .H_BP(4), .DW(16)) dut (
        .clk(clk), .rstn(rstn), .cam_href(cam_href), .cam_vsync(cam_vsync),
        .cam_data(cam_data), .hsync(hsync), .vsync(vsync), .hsync_o(hsync_o),
        .vsync_o(vsync_o), .de(de), .pix_data(pix_data), .ovf(ovf), .udf(udf),
        .trunc(trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input logic o, input logic u, input logic t);
        chk({tag, " ovf"}, 32'(ovf), 32'(o));
        chk({tag, " udf"}, 32'(udf), 32'(u));
        chk({tag, " trunc"}, 32'(trunc), 32'(t));
    endtask

    function automatic logic [127:0] pk(input logic [15:0] base, input int n);
        logic [127:0] v = '0;
        for (int i = 0; i < n; i++) v[i*16 +: 16] = base + 16'(i);
        return v;
    endfunction

    task automatic cam_line(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            cam_href = 1'b1;
            cam_data = base + 16'(i);
            @(posedge clk); #1;
        end
        cam_href = 1'b0;
        cam_data = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // hsync low for 2 clk; the fall registers at the first edge (k=1), so de spans k=7..14
    task automatic replay(input string tag, input logic [127:0] exp, input bit on,
                          input bit vs_too, input bit flush);
        hsync = 1'b0;
        vsync = vs_too;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin
                hsync = 1'b1;
                vsync = 1'b0;
            end
            if (flush && k == 9) cam_vsync = 1'b1;
            if (flush && k == 11) cam_vsync = 1'b0;
            @(negedge clk);
            begin
                bit    win = on && k >= 7 && k <= 14;
                int    idx = win ? k - 7 : 0;
                bit    sp = (k == 2 || k == 3);
                chk($sformatf("%s k%0d de", tag, k), 32'(de), 32'(win));
                chk($sformatf("%s k%0d pix", tag, k), 32'(pix_data), win ? 32'(exp[idx*16 +: 16]) : 32'h0);
                chk($sformatf("%s k%0d hsync_o", tag, k), 32'(hsync_o), 32'(!sp));
                chk($sformatf("%s k%0d vsync_o", tag, k), 32'(vsync_o), 32'(vs_too && sp));
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst de", 32'(de), 32'h0);
        chk("rst pix", 32'(pix_data), 32'h0);
        chk("rst hsync_o", 32'(hsync_o), 32'h0);
        chk("rst vsync_o", 32'(vsync_o), 32'h0);
        flags("rst", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        cam_line(8, 16'h0001);
        replay("single", pk(16'h0001, 8), 1'b1, 1'b0, 1'b0);
        flags("single", 1'b0, 1'b0, 1'b0);

        cam_line(5, 16'h0001);
        replay("short", pk(16'h0001, 5), 1'b1, 1'b0, 1'b0);
        flags("short", 1'b0, 1'b0, 1'b0);

        cam_line(11, 16'h0021);
        replay("long", pk(16'h0021, 8), 1'b1, 1'b0, 1'b0);
        flags("long", 1'b0, 1'b0, 1'b1);

        replay("under", '0, 1'b0, 1'b1, 1'b0);
        flags("under", 1'b0, 1'b1, 1'b1);

        cam_line(8, 16'h0101);
        cam_line(8, 16'h0201);
        chk("ovf before 3rd", 32'(ovf), 32'h0);
        cam_line(8, 16'h0301);
        flags("ovf", 1'b1, 1'b1, 1'b1);
        replay("ovf l1", pk(16'h0101, 8), 1'b1, 1'b0, 1'b0);
        replay("ovf l2", pk(16'h0201, 8), 1'b1, 1'b0, 1'b0);

        cam_line(8, 16'h0401);
        cam_line(8, 16'h0501);
        replay("flush rd", pk(16'h0401, 8), 1'b1, 1'b0, 1'b1);
        replay("flush empty", '0, 1'b0, 1'b0, 1'b0);
        cam_line(8, 16'h0601);
        replay("post flush", pk(16'h0601, 8), 1'b1, 1'b0, 1'b0);

        cam_line(8, 16'h0701);
        hsync = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 2) hsync = 1'b1;
        end
        @(negedge clk);
        chk("mid act de", 32'(de), 32'h1);
        chk("mid act pix", 32'(pix_data), 32'h0703);
        #2 rstn = 1'b0;
        #1;
        chk("async de", 32'(de), 32'h0);
        chk("async pix", 32'(pix_data), 32'h0);
        chk("async hsync_o", 32'(hsync_o), 32'h0);
        flags("async", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        flags("released", 1'b0, 1'b0, 1'b0);
        replay("after rst", '0, 1'b0, 1'b0, 1'b0);
        flags("after rst", 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
